// File: rtl/sha2_pkg.sv
// SHA-2 round engine shared types and helpers.
// Mode/state encodings, round counts, Sigma rotation amounts, Ch/Maj.
package sha2_pkg;

  localparam int WORD_W  = 64;
  localparam int RND_256 = 64;
  localparam int RND_512 = 80;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [7:0][WORD_W-1:0] hash_t;

  typedef enum logic {
    SHA256 = 1'b0,
    SHA512 = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int R256_S0_A = 2;
  localparam int R256_S0_B = 13;
  localparam int R256_S0_C = 22;
  localparam int R256_S1_A = 6;
  localparam int R256_S1_B = 11;
  localparam int R256_S1_C = 25;

  localparam int R512_S0_A = 28;
  localparam int R512_S0_B = 34;
  localparam int R512_S0_C = 39;
  localparam int R512_S1_A = 14;
  localparam int R512_S1_B = 18;
  localparam int R512_S1_C = 41;

  function automatic word_t rotr64(
    word_t x,
    int    n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] rotr32(
    logic [31:0] x,
    int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(
    word_t e,
    word_t f,
    word_t g
  );
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(
    word_t a,
    word_t b,
    word_t c
  );
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // 32-bit mode keeps the upper half of every word at zero
  function automatic word_t word_mask(logic m512);
    return m512 ? 64'hffff_ffff_ffff_ffff
                : 64'h0000_0000_ffff_ffff;
  endfunction

endpackage

// File: rtl/sha2_big_sigma.sv
// Combinational SHA-2 big Sigma (Sigma0 or Sigma1 by parameter).
// Ports: mode (0=32-bit, 1=64-bit), x word in, y word out.
module sha2_big_sigma
  import sha2_pkg::*;
#(
  parameter bit SIGMA1 = 1'b0
) (
  input  logic  mode,
  input  word_t x,
  output word_t y
);

  localparam int A32 = SIGMA1 ? R256_S1_A : R256_S0_A;
  localparam int B32 = SIGMA1 ? R256_S1_B : R256_S0_B;
  localparam int C32 = SIGMA1 ? R256_S1_C : R256_S0_C;
  localparam int A64 = SIGMA1 ? R512_S1_A : R512_S0_A;
  localparam int B64 = SIGMA1 ? R512_S1_B : R512_S0_B;
  localparam int C64 = SIGMA1 ? R512_S1_C : R512_S0_C;

  logic [31:0] y32;
  word_t       y64;

  assign y32 = rotr32(x[31:0], A32)
             ^ rotr32(x[31:0], B32)
             ^ rotr32(x[31:0], C32);

  assign y64 = rotr64(x, A64)
             ^ rotr64(x, B64)
             ^ rotr64(x, C64);

  assign y = mode ? y64 : {32'h0, y32};

endmodule

// File: rtl/sha2_round_engine.sv
// Iterative SHA-256/SHA-512 compression, one round per accepted W+K word.
// Ports: init (hash+mode), wk stream, digest out, all valid/ready; busy.
module sha2_round_engine
  import sha2_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ROUNDS_256 = RND_256,
  parameter int ROUNDS_512 = RND_512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  init_valid,
  output logic                  init_ready,
  input  logic [511:0]          init_hash,
  input  logic                  wk_valid,
  output logic                  wk_ready,
  input  logic [DATA_WIDTH-1:0] wk_data,
  output logic                  digest_valid,
  input  logic                  digest_ready,
  output logic [511:0]          digest,
  output logic                  busy
);

  localparam logic [6:0] LAST_256 = 7'(ROUNDS_256 - 1);
  localparam logic [6:0] LAST_512 = 7'(ROUNDS_512 - 1);

  state_e     state;
  mode_e      mode_r;
  logic [6:0] cnt;
  hash_t      wv;
  hash_t      h_reg;
  hash_t      dg;
  logic       dv;

  hash_t      init_w;
  hash_t      init_m;
  hash_t      wv_nxt;
  hash_t      dg_nxt;

  word_t      a, b, c, d, e, f, g, h;
  word_t      mask;
  word_t      wk;
  word_t      s0, s1;
  word_t      t1, t2;
  logic       m512;
  logic       last;

  assign {a, b, c, d, e, f, g, h} = wv;

  assign m512 = (mode_r == SHA512);
  assign mask = word_mask(m512);
  assign wk   = word_t'(wk_data) & mask;

  sha2_big_sigma #(
    .SIGMA1(1'b0)
  ) u_sigma0 (
    .mode(m512),
    .x   (a),
    .y   (s0)
  );

  sha2_big_sigma #(
    .SIGMA1(1'b1)
  ) u_sigma1 (
    .mode(m512),
    .x   (e),
    .y   (s1)
  );

  assign t1 = h + s1 + ch(e, f, g) + wk;
  assign t2 = s0 + maj(a, b, c);

  assign wv_nxt = {
    (t1 + t2) & mask, a, b, c,
    (d + t1) & mask,  e, f, g
  };

  assign last = m512 ? (cnt == LAST_512)
                     : (cnt == LAST_256);

  assign init_w = init_hash;

  always_comb begin
    init_m = '0;
    for (int i = 0; i < 8; i++) begin
      init_m[i] = init_w[i] & word_mask(mode);
    end
  end

  // Feed-forward uses the post-round state so the
  // digest is ready on the cycle DONE is entered.
  always_comb begin
    dg_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      dg_nxt[i] = (h_reg[i] + wv_nxt[i]) & mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_r <= SHA256;
      cnt    <= '0;
      wv     <= '0;
      h_reg  <= '0;
      dg     <= '0;
      dv     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (init_valid) begin
            wv     <= init_m;
            h_reg  <= init_m;
            mode_r <= mode_e'(mode);
            cnt    <= '0;
            state  <= ROUND;
          end
        end
        ROUND: begin
          if (wk_valid) begin
            wv  <= wv_nxt;
            cnt <= cnt + 7'd1;
            if (last) begin
              dg    <= dg_nxt;
              dv    <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (digest_ready) begin
            dv    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign init_ready   = (state == IDLE);
  assign wk_ready     = (state == ROUND);
  assign busy         = (state != IDLE);
  assign digest_valid = dv;
  assign digest       = dg;

endmodule

// File: tb/tb_sha2_round_engine.sv
// Self-checking bench for sha2_round_engine.
// Reference schedule/compression model plus digest scoreboard.
module tb_sha2_round_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic         init_valid;
  logic         init_ready;
  logic [511:0] init_hash;
  logic         wk_valid;
  logic         wk_ready;
  logic [63:0]  wk_data;
  logic         digest_valid;
  logic         digest_ready;
  logic [511:0] digest;
  logic         busy;

  always #5 clk = ~clk;

  sha2_round_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .init_valid  (init_valid),
    .init_ready  (init_ready),
    .init_hash   (init_hash),
    .wk_valid    (wk_valid),
    .wk_ready    (wk_ready),
    .wk_data     (wk_data),
    .digest_valid(digest_valid),
    .digest_ready(digest_ready),
    .digest      (digest),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_dig    = 0;

  logic [511:0] sb_q [$];

  task automatic check(
    string        tag,
    logic [511:0] got,
    logic [511:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  localparam logic [511:0] H256 = {
    32'h0, 32'h6a09e667, 32'h0, 32'hbb67ae85,
    32'h0, 32'h3c6ef372, 32'h0, 32'ha54ff53a,
    32'h0, 32'h510e527f, 32'h0, 32'h9b05688c,
    32'h0, 32'h1f83d9ab, 32'h0, 32'h5be0cd19
  };
  localparam logic [511:0] EXP256 = {
    32'h0, 32'hba7816bf, 32'h0, 32'h8f01cfea,
    32'h0, 32'h414140de, 32'h0, 32'h5dae2223,
    32'h0, 32'hb00361a3, 32'h0, 32'h96177a9c,
    32'h0, 32'hb410ff61, 32'h0, 32'hf20015ad
  };
  localparam logic [511:0] H512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [511:0] EXP512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131,
    64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
    64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f
  };

  // SHA-512 constants; SHA-256 uses the upper halves of the first 64
  logic [63:0] k512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd,
    64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019,
    64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe,
    64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
    64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
    64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
    64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210,
    64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
    64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
    64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
    64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
    64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910,
    64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
    64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
    64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
    64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9,
    64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207,
    64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
    64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493,
    64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
    64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  logic [63:0] msg    [16];
  logic [63:0] wk_tab [80];

  function automatic logic [63:0] rr(
    logic [63:0] x, int n, bit m512
  );
    if (m512) return (x >> n) | (x << (64 - n));
    return {32'h0,
            (x[31:0] >> n) | (x[31:0] << (32 - n))};
  endfunction

  function automatic logic [63:0] ss0(
    logic [63:0] x, bit m512
  );
    if (m512) return rr(x, 1, 1) ^ rr(x, 8, 1) ^ (x >> 7);
    return rr(x, 7, 0) ^ rr(x, 18, 0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] ss1(
    logic [63:0] x, bit m512
  );
    if (m512) return rr(x, 19, 1) ^ rr(x, 61, 1) ^ (x >> 6);
    return rr(x, 17, 0) ^ rr(x, 19, 0) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] bs0(
    logic [63:0] x, bit m512
  );
    if (m512)
      return rr(x, 28, 1) ^ rr(x, 34, 1) ^ rr(x, 39, 1);
    return rr(x, 2, 0) ^ rr(x, 13, 0) ^ rr(x, 22, 0);
  endfunction

  function automatic logic [63:0] bs1(
    logic [63:0] x, bit m512
  );
    if (m512)
      return rr(x, 14, 1) ^ rr(x, 18, 1) ^ rr(x, 41, 1);
    return rr(x, 6, 0) ^ rr(x, 11, 0) ^ rr(x, 25, 0);
  endfunction

  task automatic set_abc(bit m512);
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = m512 ? 64'h6162638000000000
                   : 64'h0000000061626380;
    msg[15] = 64'h18;
  endtask

  task automatic build_wk(bit m512);
    logic [63:0] w [80];
    logic [63:0] mk;
    logic [63:0] kt;
    int          n;
    mk = m512 ? 64'hffff_ffff_ffff_ffff
              : 64'h0000_0000_ffff_ffff;
    n  = m512 ? 80 : 64;
    for (int t = 0; t < 80; t++) begin
      w[t]      = '0;
      wk_tab[t] = '0;
    end
    for (int t = 0; t < n; t++) begin
      if (t < 16) w[t] = msg[t] & mk;
      else w[t] = (ss1(w[t-2], m512) + w[t-7]
                 + ss0(w[t-15], m512) + w[t-16]) & mk;
      kt = m512 ? k512[t] : {32'h0, k512[t][63:32]};
      wk_tab[t] = (w[t] + kt) & mk;
    end
  endtask

  function automatic logic [511:0] model(
    bit m512, logic [511:0] hin
  );
    logic [63:0]  v  [8];
    logic [63:0]  hh [8];
    logic [63:0]  mk, t1, t2;
    logic [511:0] r;
    int           n;
    mk = m512 ? 64'hffff_ffff_ffff_ffff
              : 64'h0000_0000_ffff_ffff;
    n  = m512 ? 80 : 64;
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[511-64*i -: 64] & mk;
      v[i]  = hh[i];
    end
    for (int t = 0; t < n; t++) begin
      t1 = v[7] + bs1(v[4], m512)
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + wk_tab[t];
      t2 = bs0(v[0], m512)
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = (v[3] + t1) & mk;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = (t1 + t2) & mk;
    end
    r = '0;
    for (int i = 0; i < 8; i++)
      r[511-64*i -: 64] = (hh[i] + v[i]) & mk;
    return r;
  endfunction

  // Digest monitor: scoreboard pop on handshake, stability while stalled
  logic [511:0] held;
  bit           held_v = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (digest_valid && held_v)
        check("digest_stable", digest, held);
      held_v = digest_valid && !digest_ready;
      held   = digest;
      if (digest_valid && digest_ready) begin
        if (sb_q.size() == 0)
          check("unexpected_digest", digest, '0);
        else
          check("digest", digest, sb_q.pop_front());
        n_dig++;
      end
    end
  end

  task automatic run_block(
    bit           m512,
    logic [511:0] hin,
    logic [511:0] exp,
    int           stall,
    int           rdy_delay,
    bit           noise,
    int           abort_at
  );
    int n;
    int idx;
    int guard;
    int seen;
    bit acc;
    n   = m512 ? 80 : 64;
    idx = 0;
    @(posedge clk);
    #2;
    digest_ready = 1'b0;
    mode         = m512;
    init_hash    = m512 ? hin
                        : hin | {8{$urandom, 32'h0}};
    init_valid   = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = init_ready;
      @(posedge clk);
      #2;
      guard++;
    end
    init_valid = 1'b0;
    if (!acc) begin
      check("init_timeout", 512'(acc), 512'(1));
      return;
    end
    if (abort_at == 0) sb_q.push_back(exp);
    guard = 0;
    while (idx < n && guard < 2000) begin
      wk_valid = ($urandom_range(99) >= stall);
      wk_data  = m512 ? wk_tab[idx]
                      : {$urandom, wk_tab[idx][31:0]};
      if (noise) begin
        init_valid = 1'($urandom_range(1));
        mode       = ~mode;
        init_hash  = {16{$urandom}};
      end
      @(negedge clk);
      if (noise)
        check("init_ready_in_round",
              512'(init_ready), 512'(0));
      if (wk_valid && wk_ready) begin
        if (idx == n - 1)
          check("dv_before_last",
                512'(digest_valid), 512'(0));
        idx++;
      end
      @(posedge clk);
      #2;
      guard++;
      if (abort_at != 0 && idx == abort_at) begin
        wk_valid   = 1'b0;
        init_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("abort_flags",
              512'({init_ready, wk_ready,
                    digest_valid, busy}),
              512'(4'b1000));
        check("abort_digest", digest, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        return;
      end
    end
    wk_valid   = 1'b0;
    init_valid = 1'b0;
    if (idx < n) begin
      check("stream_timeout", 512'(idx), 512'(n));
      return;
    end
    check("dv_latency", 512'(digest_valid), 512'(1));
    seen = n_dig;
    repeat (rdy_delay) @(posedge clk);
    if (rdy_delay > 0) #2;
    digest_ready = 1'b1;
    guard = 0;
    while (n_dig == seen && guard < 50) begin
      @(posedge clk);
      #2;
      guard++;
    end
    digest_ready = 1'b0;
    check("digest_handshake",
          512'(n_dig - seen), 512'(1));
    check("init_ready_after",
          512'({init_ready, digest_valid, busy}),
          512'(3'b100));
  endtask

  logic [511:0] exp2;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    mode         = 1'b0;
    init_valid   = 1'b0;
    init_hash    = '0;
    wk_valid     = 1'b0;
    wk_data      = '0;
    digest_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_flags",
          512'({init_ready, wk_ready, digest_valid, busy}),
          512'(4'b1000));
    check("reset_digest", digest, '0);
    rst_n = 1'b1;

    // wk_valid while idle must be ignored
    repeat (3) begin
      @(posedge clk);
      #2;
      wk_valid = 1'b1;
      wk_data  = {$urandom, $urandom};
      @(negedge clk);
      check("wk_ready_idle",
            512'({wk_ready, busy}), 512'(2'b00));
    end
    wk_valid = 1'b0;

    set_abc(1'b0);
    build_wk(1'b0);
    run_block(1'b0, H256, EXP256, 0, 0, 1'b0, 0);

    set_abc(1'b1);
    build_wk(1'b1);
    run_block(1'b1, H512, EXP512, 0, 0, 1'b0, 0);

    set_abc(1'b0);
    build_wk(1'b0);
    run_block(1'b0, H256, EXP256, 50, 10, 1'b1, 0);

    set_abc(1'b1);
    build_wk(1'b1);
    run_block(1'b1, H512, '0, 0, 0, 1'b0, 31);
    run_block(1'b1, H512, EXP512, 0, 0, 1'b0, 0);

    set_abc(1'b0);
    build_wk(1'b0);
    run_block(1'b0, H256, EXP256, 0, 0, 1'b0, 0);
    for (int i = 0; i < 16; i++)
      msg[i] = {32'h0, $urandom};
    build_wk(1'b0);
    exp2 = model(1'b0, EXP256);
    run_block(1'b0, EXP256, exp2, 0, 0, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", 512'(sb_q.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
